// File: rtl/io_pkg.sv
// Shared constants and TX state encoding for the io_port block.
package io_pkg;

  localparam int RX_DEPTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_rx_fifo.sv
// Receive byte FIFO: registered pointers/count, combinational head read (0x00 when empty).
module io_rx_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [7:0]    head_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // Requests against a full/empty FIFO are dropped here so callers need not gate them.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_port.sv
// CPU-facing I/O port: buffered receive path, single-byte transmit FSM and interrupt enable.
module io_port
  import io_pkg::*;
#(
  parameter int RX_DEPTH = RX_DEPTH_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       INP,
  input  logic       OUT,
  input  logic [7:0] OUT_DATA,
  input  logic       ION,
  input  logic       IOF,
  input  logic       INTACK,
  output logic [7:0] INPR,
  output logic       FGI,
  output logic       FGO,
  output logic       IEN,
  output logic       IRQ,
  input  logic       DEV_RX_VALID,
  input  logic [7:0] DEV_RX_DATA,
  output logic       DEV_RX_READY,
  output logic       DEV_TX_VALID,
  output logic [7:0] DEV_TX_DATA,
  input  logic       DEV_TX_READY
);

  localparam int AW = $clog2(RX_DEPTH);

  logic          rx_full, rx_empty;
  logic [AW:0]   rx_count;
  tx_state_e     state_q, state_d;
  logic [7:0]    outr_q, outr_d;
  logic          ien_q, ien_d;

  io_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_n_i (RESET_N),
    .push_i  (DEV_RX_VALID),
    .wdata_i (DEV_RX_DATA),
    .pop_i   (INP),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (INPR),
    .count_o (rx_count)
  );

  assign DEV_RX_READY = !rx_full;
  assign FGI          = !rx_empty;

  always_comb begin
    state_d = state_q;
    outr_d  = outr_q;
    case (state_q)
      IDLE: if (OUT) begin
        outr_d  = OUT_DATA;
        state_d = SEND;
      end
      SEND: if (DEV_TX_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clearing sources take priority over a same-cycle ION.
  always_comb begin
    ien_d = ien_q;
    if (IOF || INTACK) ien_d = 1'b0;
    else if (ION)      ien_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      outr_q  <= 8'h00;
      ien_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      outr_q  <= outr_d;
      ien_q   <= ien_d;
    end
  end

  assign FGO          = (state_q == IDLE);
  assign DEV_TX_VALID = (state_q == SEND);
  assign DEV_TX_DATA  = outr_q;
  assign IEN          = ien_q;
  assign IRQ          = ien_q && (FGI || FGO);

endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port; outputs sampled on the falling clock edge.
module tb_io_port;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       INP, OUT, ION, IOF, INTACK;
  logic [7:0] OUT_DATA;
  logic [7:0] INPR;
  logic       FGI, FGO, IEN, IRQ;
  logic       DEV_RX_VALID;
  logic [7:0] DEV_RX_DATA;
  logic       DEV_RX_READY;
  logic       DEV_TX_VALID;
  logic [7:0] DEV_TX_DATA;
  logic       DEV_TX_READY;

  int nchk  = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  io_port #(.RX_DEPTH(4)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .INP          (INP),
    .OUT          (OUT),
    .OUT_DATA     (OUT_DATA),
    .ION          (ION),
    .IOF          (IOF),
    .INTACK       (INTACK),
    .INPR         (INPR),
    .FGI          (FGI),
    .FGO          (FGO),
    .IEN          (IEN),
    .IRQ          (IRQ),
    .DEV_RX_VALID (DEV_RX_VALID),
    .DEV_RX_DATA  (DEV_RX_DATA),
    .DEV_RX_READY (DEV_RX_READY),
    .DEV_TX_VALID (DEV_TX_VALID),
    .DEV_TX_DATA  (DEV_TX_DATA),
    .DEV_TX_READY (DEV_TX_READY)
  );

  task automatic test_reset();
    RESET_N = 1'b0; INP = 0; OUT = 0; OUT_DATA = 8'h00; ION = 0; IOF = 0; INTACK = 0;
    DEV_RX_VALID = 0; DEV_RX_DATA = 8'h00; DEV_TX_READY = 0;
    #3;
    nchk++;
    if ({FGI, FGO, IEN, IRQ, DEV_RX_READY, DEV_TX_VALID} !== 6'b010010) begin
      nfail++;
      $display("FAIL reset_flags: got FGI/FGO/IEN/IRQ/RDY/TXV=%b want 010010",
               {FGI, FGO, IEN, IRQ, DEV_RX_READY, DEV_TX_VALID});
    end
    nchk++;
    if (INPR !== 8'h00 || DEV_TX_DATA !== 8'h00) begin
      nfail++;
      $display("FAIL reset_data: got INPR=%h TXD=%h want 00 00", INPR, DEV_TX_DATA);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_rx();
    DEV_RX_VALID = 1; DEV_RX_DATA = 8'h41;
    @(negedge CLK);
    DEV_RX_VALID = 0;
    nchk++;
    if (FGI !== 1'b1 || INPR !== 8'h41) begin
      nfail++;
      $display("FAIL rx_push: got FGI=%b INPR=%h want 1 41", FGI, INPR);
    end
    INP = 1;
    @(negedge CLK);
    INP = 0;
    nchk++;
    if (FGI !== 1'b0 || INPR !== 8'h00) begin
      nfail++;
      $display("FAIL rx_pop: got FGI=%b INPR=%h want 0 00", FGI, INPR);
    end
    INP = 1;  // INP while empty must change nothing
    @(negedge CLK);
    INP = 0;
    nchk++;
    if (FGI !== 1'b0 || DEV_RX_READY !== 1'b1) begin
      nfail++;
      $display("FAIL rx_pop_empty: got FGI=%b RDY=%b want 0 1", FGI, DEV_RX_READY);
    end
    $display("test_single_rx done");
  endtask

  task automatic test_fifo_full();
    logic rdy;
    DEV_RX_VALID = 1; DEV_RX_DATA = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      nchk++;
      if (DEV_RX_READY !== (i < 4)) begin
        nfail++;
        $display("FAIL fill_ready_%0d: got %b want %b", i, DEV_RX_READY, (i < 4));
      end
      DEV_RX_DATA = 8'(i + 1);
    end
    repeat (2) @(negedge CLK);
    nchk++;
    if (DEV_RX_READY !== 1'b0 || INPR !== 8'h01) begin
      nfail++;
      $display("FAIL full_hold: got RDY=%b INPR=%h want 0 01", DEV_RX_READY, INPR);
    end
    for (int k = 0; k < 5; k++) begin
      nchk++;
      if (FGI !== 1'b1 || INPR !== 8'(k + 1)) begin
        nfail++;
        $display("FAIL drain_%0d: got FGI=%b INPR=%h want 1 %h", k, FGI, INPR, 8'(k + 1));
      end
      rdy = DEV_RX_READY;
      INP = 1;
      @(negedge CLK);
      if (rdy && DEV_RX_VALID) DEV_RX_VALID = 0;
    end
    INP = 0;
    nchk++;
    if (FGI !== 1'b0 || DEV_RX_VALID !== 1'b0) begin
      nfail++;
      $display("FAIL drain_end: got FGI=%b dev_valid=%b want 0 0", FGI, DEV_RX_VALID);
    end
    $display("test_fifo_full done");
  endtask

  task automatic test_tx();
    OUT = 1; OUT_DATA = 8'h5A; DEV_TX_READY = 0;
    @(negedge CLK);
    OUT = 0; OUT_DATA = 8'hC3;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) DEV_TX_READY = 1;
      nchk++;
      if (FGO !== 1'b0 || DEV_TX_VALID !== 1'b1 || DEV_TX_DATA !== 8'h5A) begin
        nfail++;
        $display("FAIL tx_hold_%0d: got FGO=%b V=%b D=%h want 0 1 5a", c, FGO, DEV_TX_VALID, DEV_TX_DATA);
      end
      @(negedge CLK);
    end
    DEV_TX_READY = 0;
    nchk++;
    if (FGO !== 1'b1 || DEV_TX_VALID !== 1'b0) begin
      nfail++;
      $display("FAIL tx_done: got FGO=%b V=%b want 1 0", FGO, DEV_TX_VALID);
    end
    $display("test_tx done");
  endtask

  task automatic test_out_during_send();
    int accepted = 0;
    OUT = 1; OUT_DATA = 8'h11; DEV_TX_READY = 0;
    @(negedge CLK);
    OUT_DATA = 8'h22;  // OUT still high while in SEND
    @(negedge CLK);
    OUT = 0;
    nchk++;
    if (DEV_TX_DATA !== 8'h11 || DEV_TX_VALID !== 1'b1) begin
      nfail++;
      $display("FAIL send_ignore: got V=%b D=%h want 1 11", DEV_TX_VALID, DEV_TX_DATA);
    end
    DEV_TX_READY = 1;
    for (int c = 0; c < 3; c++) begin
      if (DEV_TX_VALID) begin
        accepted++;
        nchk++;
        if (DEV_TX_DATA !== 8'h11) begin
          nfail++;
          $display("FAIL send_byte: got %h want 11", DEV_TX_DATA);
        end
      end
      @(negedge CLK);
    end
    DEV_TX_READY = 0;
    nchk++;
    if (accepted != 1 || DEV_TX_DATA !== 8'h11) begin
      nfail++;
      $display("FAIL send_count: got %0d bytes OUTR=%h want 1 11", accepted, DEV_TX_DATA);
    end
    $display("test_out_during_send done");
  endtask

  task automatic test_ien();
    ION = 1; IOF = 1;
    @(negedge CLK);
    IOF = 0;
    nchk++;
    if (IEN !== 1'b0) begin
      nfail++;
      $display("FAIL ion_iof: got IEN=%b want 0", IEN);
    end
    @(negedge CLK);
    ION = 0;
    nchk++;
    if (IEN !== 1'b1 || IRQ !== 1'b1) begin
      nfail++;
      $display("FAIL ion: got IEN=%b IRQ=%b want 1 1", IEN, IRQ);
    end
    @(negedge CLK);
    nchk++;
    if (IEN !== 1'b1) begin
      nfail++;
      $display("FAIL ien_hold: got IEN=%b want 1", IEN);
    end
    INTACK = 1; ION = 1;
    @(negedge CLK);
    INTACK = 0; ION = 0;
    nchk++;
    if (IEN !== 1'b0 || IRQ !== 1'b0) begin
      nfail++;
      $display("FAIL intack: got IEN=%b IRQ=%b want 0 0", IEN, IRQ);
    end
    $display("test_ien done");
  endtask

  task automatic test_reset_mid_send();
    DEV_RX_VALID = 1; DEV_RX_DATA = 8'hA1;
    @(negedge CLK);
    DEV_RX_DATA = 8'hA2;
    @(negedge CLK);
    DEV_RX_VALID = 0;
    OUT = 1; OUT_DATA = 8'h77; DEV_TX_READY = 0;
    @(negedge CLK);
    OUT = 0;
    nchk++;
    if (FGI !== 1'b1 || DEV_TX_VALID !== 1'b1 || INPR !== 8'hA1) begin
      nfail++;
      $display("FAIL pre_reset: got FGI=%b V=%b INPR=%h want 1 1 a1", FGI, DEV_TX_VALID, INPR);
    end
    #2 RESET_N = 0;
    #1;
    nchk++;
    if ({DEV_TX_VALID, FGO, FGI, DEV_RX_READY} !== 4'b0101 || INPR !== 8'h00 || DEV_TX_DATA !== 8'h00) begin
      nfail++;
      $display("FAIL async_reset: got V/FGO/FGI/RDY=%b INPR=%h TXD=%h want 0101 00 00",
               {DEV_TX_VALID, FGO, FGI, DEV_RX_READY}, INPR, DEV_TX_DATA);
    end
    @(negedge CLK);
    RESET_N = 1; DEV_TX_READY = 1;
    repeat (2) begin
      @(negedge CLK);
      nchk++;
      if (DEV_TX_VALID !== 1'b0 || FGO !== 1'b1) begin
        nfail++;
        $display("FAIL no_resend: got V=%b FGO=%b want 0 1", DEV_TX_VALID, FGO);
      end
    end
    DEV_TX_READY = 0;
    $display("test_reset_mid_send done");
  endtask

  initial begin
    test_reset();
    test_single_rx();
    test_fifo_full();
    test_tx();
    test_out_during_send();
    test_ien();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
